// File: rtl/data_mem_responder_if.sv
// Request/response channel pair between the CPU load/store port and the data memory.
`default_nettype none

interface data_mem_responder_if #(
   parameter int WIDTH = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [WIDTH-1:0]     req_addr;
   logic [WIDTH-1:0]     req_wdata;
   logic [WIDTH/8-1:0]   req_be;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [WIDTH-1:0]     rsp_rdata;
   logic                 rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module  : data_mem_responder
// Brief   : Word-wide data memory with programmable wait states and byte-enable writes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_responder #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  wire logic              clk,
   input  wire logic              rst,
   data_mem_responder_if.slave    io_bus
);
   localparam int NBYTES   = WIDTH / 8;
   localparam int ADDR_LSB = (NBYTES > 1) ? $clog2(NBYTES) : 0;
   localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   localparam logic [WIDTH-1:0] c_LSB_MASK = WIDTH'(NBYTES - 1);
   localparam logic [WIDTH-1:0] c_DEPTH    = WIDTH'(DEPTH);
   localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_we;
   logic [IDX_W-1:0]    r_idx;
   logic [WIDTH-1:0]    r_wdata;
   logic [NBYTES-1:0]   r_be;
   logic                r_bad;
   logic                r_rsp_valid;
   logic [WIDTH-1:0]    r_rsp_rdata;
   logic                r_rsp_err;
   logic [WIDTH-1:0]    r_mem [DEPTH];

   logic                w_accept;
   logic                w_bad;
   logic                w_enter_resp;
   logic                w_commit;

   assign io_bus.req_ready = (r_state == S_IDLE) && rst;
   assign io_bus.rsp_valid = r_rsp_valid;
   assign io_bus.rsp_rdata = r_rsp_rdata;
   assign io_bus.rsp_err   = r_rsp_err;

   assign w_accept     = io_bus.req_valid && io_bus.req_ready;
   assign w_bad        = ((io_bus.req_addr & c_LSB_MASK) != '0) ||
                         ((io_bus.req_addr >> ADDR_LSB) >= c_DEPTH);
   // The counter spans WAIT_STATES+1 cycles so that the response lands WAIT_STATES+1 edges after accept.
   assign w_enter_resp = (r_state == S_WAIT) && (r_cnt == '0);
   assign w_commit     = rst && w_enter_resp && r_we && !r_bad;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_state_nxt = S_RESP;
         S_RESP:  if (io_bus.rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_idx       <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_bad       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt   <= c_CNT_LOAD;
            r_we    <= io_bus.req_we;
            r_idx   <= io_bus.req_addr[ADDR_LSB +: IDX_W];
            r_wdata <= io_bus.req_wdata;
            r_be    <= io_bus.req_be;
            r_bad   <= w_bad;
         end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_enter_resp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_bad;
            r_rsp_rdata <= (!r_we && !r_bad) ? r_mem[r_idx] : '0;
         end else if (r_state == S_RESP && io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   // Array is deliberately left out of reset; only the commit is gated by it.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
         end
      end
   end
endmodule

`default_nettype wire
